eth_fwd_scheduler: RTL and testbench

//  Shares one TX MAC byte interface between two RX frame FIFOs (bridge ports A/B).

---
 rtl/eth_bridge_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/eth_fwd_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_eth_fwd_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_bridge_pkg.sv
// Shared types and defaults for the two-port Ethernet forwarding scheduler.
package eth_bridge_pkg;

   typedef enum logic [1:0] {
      FWD_IDLE  = 2'd0,
      FWD_XFER  = 2'd1,
      FWD_DRAIN = 2'd2,
      FWD_IFG   = 2'd3
   } fwd_state_t;

   localparam int PORT_A = 0;
   localparam int PORT_B = 1;

   localparam int DEF_MAX_LEN    = 1518;
   localparam int DEF_IFG_CYCLES = 12;

   // Round-robin pick between two requesters; on a tie the port that did not
   // win last time is chosen.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_b);
      logic [1:0] pick;
      pick = req;
      if (req == 2'b11) begin
         pick = last_b ? 2'b01 : 2'b10;
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered one-hot grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       arb_en,
   input  logic       clr,
   output logic [1:0] grant
);
   import eth_bridge_pkg::*;

   logic       last_b;
   logic [1:0] pick;

   assign pick = rr_pick(req, last_b);

   // Register the winner and remember it so the other port wins the next tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant  <= 2'b00;
         last_b <= 1'b1;
      end else if (clr) begin
         grant  <= 2'b00;
      end else if (arb_en && (req != 2'b00)) begin
         grant  <= pick;
         last_b <= pick[PORT_B];
      end
   end

endmodule

// File: rtl/eth_fwd_scheduler.sv
// Frame-level round-robin scheduler sharing one TX MAC byte stream between
// two FWFT frame FIFOs, with truncation at MAX_LEN and an inter-frame gap.
module eth_fwd_scheduler
   import eth_bridge_pkg::*;
#(
   parameter int MAX_LEN    = DEF_MAX_LEN,
   parameter int IFG_CYCLES = DEF_IFG_CYCLES,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_en,
   input  logic             a_frame_avail,
   input  logic             a_empty,
   input  logic [7:0]       a_data,
   input  logic             a_last,
   output logic             a_rd_en,
   input  logic             b_frame_avail,
   input  logic             b_empty,
   input  logic [7:0]       b_data,
   input  logic             b_last,
   output logic             b_rd_en,
   input  logic             tx_mac_ready,
   output logic [7:0]       tx_mac_data,
   output logic             tx_mac_valid,
   output logic             tx_mac_last,
   output logic [1:0]       grant,
   output logic             busy,
   output logic             trunc_pulse,
   output logic [CNT_W-1:0] a_frames,
   output logic [CNT_W-1:0] b_frames
);

   localparam int LEN_W    = (($clog2(MAX_LEN) + 1) > 11) ? ($clog2(MAX_LEN) + 1) : 11;
   localparam int IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam int IFG_LAST = (IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0;
   localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
   localparam logic [IFG_W-1:0] IFG_END  = IFG_W'(IFG_LAST);
   // With no gap configured, a finished frame returns straight to IDLE
   localparam fwd_state_t END_STATE = (IFG_CYCLES == 0) ? FWD_IDLE : FWD_IFG;

   fwd_state_t       state;
   fwd_state_t       next_state;
   logic [1:0]       req;
   logic             arb_en;
   logic             grant_clr;
   logic             sel_b;
   logic             sel_empty;
   logic             sel_last;
   logic [7:0]       sel_data;
   logic             sel_rd;
   logic             xfer_accept;
   logic             frame_done;
   logic             trunc_hit;
   logic             at_max;
   logic [LEN_W-1:0] len_cnt;
   logic [IFG_W-1:0] ifg_cnt;

   assign req[PORT_A] = a_frame_avail;
   assign req[PORT_B] = b_frame_avail;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .arb_en (arb_en),
      .clr    (grant_clr),
      .grant  (grant)
   );

   // The granted port owns the datapath; the other port sees no reads
   assign sel_b     = grant[PORT_B];
   assign sel_empty = sel_b ? b_empty : a_empty;
   assign sel_last  = sel_b ? b_last  : a_last;
   assign sel_data  = sel_b ? b_data  : a_data;
   assign at_max    = (len_cnt == LEN_LAST);

   assign a_rd_en     = sel_rd && grant[PORT_A];
   assign b_rd_en     = sel_rd && grant[PORT_B];
   assign tx_mac_data = tx_mac_valid ? sel_data : 8'h00;
   assign tx_mac_last = tx_mac_valid && (sel_last || at_max);
   assign busy        = (state != FWD_IDLE);

   // Next-state and per-cycle control decode
   always_comb begin
      next_state   = state;
      arb_en       = 1'b0;
      tx_mac_valid = 1'b0;
      sel_rd       = 1'b0;
      xfer_accept  = 1'b0;
      frame_done   = 1'b0;
      trunc_hit    = 1'b0;
      unique case (state)
         FWD_IDLE: begin
            if (cfg_en && (req != 2'b00)) begin
               arb_en     = 1'b1;
               next_state = FWD_XFER;
            end
         end
         FWD_XFER: begin
            tx_mac_valid = !sel_empty;
            sel_rd       = !sel_empty && tx_mac_ready;
            xfer_accept  = sel_rd;
            if (sel_rd) begin
               if (sel_last) begin
                  frame_done = 1'b1;
                  next_state = END_STATE;
               end else if (at_max) begin
                  frame_done = 1'b1;
                  trunc_hit  = 1'b1;
                  next_state = FWD_DRAIN;
               end
            end
         end
         FWD_DRAIN: begin
            // Discard the tail of an over-length frame up to its last byte
            sel_rd = !sel_empty;
            if (!sel_empty && sel_last) begin
               next_state = END_STATE;
            end
         end
         FWD_IFG: begin
            if (ifg_cnt == IFG_END) begin
               next_state = FWD_IDLE;
            end
         end
         default: next_state = FWD_IDLE;
      endcase
      grant_clr = (state != FWD_IDLE) && (next_state == FWD_IDLE);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FWD_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Bytes accepted by the MAC in the current frame, restarted at each grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_cnt <= '0;
      end else if (arb_en) begin
         len_cnt <= '0;
      end else if (xfer_accept) begin
         len_cnt <= len_cnt + 1'b1;
      end
   end

   // Idle-gap timer, held at zero outside the gap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifg_cnt <= '0;
      end else if (state != FWD_IFG) begin
         ifg_cnt <= '0;
      end else begin
         ifg_cnt <= ifg_cnt + 1'b1;
      end
   end

   // One-cycle flag following the byte at which a frame was cut
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trunc_pulse <= 1'b0;
      end else begin
         trunc_pulse <= trunc_hit;
      end
   end

   // Per-port forwarded-frame counters; truncated frames count as forwarded
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_frames <= '0;
         b_frames <= '0;
      end else if (frame_done) begin
         if (grant[PORT_B]) begin
            b_frames <= b_frames + 1'b1;
         end else begin
            a_frames <= a_frames + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_eth_fwd_scheduler.sv
// Scoreboard bench for eth_fwd_scheduler: bench-side FIFOs, frame-level
// round-robin reference model, and a monitor comparing every MAC handshake.
module tb_eth_fwd_scheduler;

   localparam int MAX_LEN    = 1518;
   localparam int IFG_CYCLES = 12;
   localparam int CNT_W      = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_en;
   logic             a_frame_avail, a_empty, a_last, a_rd_en;
   logic [7:0]       a_data;
   logic             b_frame_avail, b_empty, b_last, b_rd_en;
   logic [7:0]       b_data;
   logic             tx_mac_ready;
   logic [7:0]       tx_mac_data;
   logic             tx_mac_valid, tx_mac_last;
   logic [1:0]       grant;
   logic             busy, trunc_pulse;
   logic [CNT_W-1:0] a_frames, b_frames;

   eth_fwd_scheduler #(.MAX_LEN(MAX_LEN), .IFG_CYCLES(IFG_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .cfg_en(cfg_en),
      .a_frame_avail(a_frame_avail), .a_empty(a_empty), .a_data(a_data), .a_last(a_last), .a_rd_en(a_rd_en),
      .b_frame_avail(b_frame_avail), .b_empty(b_empty), .b_data(b_data), .b_last(b_last), .b_rd_en(b_rd_en),
      .tx_mac_ready(tx_mac_ready), .tx_mac_data(tx_mac_data), .tx_mac_valid(tx_mac_valid),
      .tx_mac_last(tx_mac_last), .grant(grant), .busy(busy), .trunc_pulse(trunc_pulse),
      .a_frames(a_frames), .b_frames(b_frames)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // bench FIFO contents: {last, data}
   logic [8:0] aq[$];
   logic [8:0] bq[$];
   int  a_cnt_frames = 0, b_cnt_frames = 0;
   logic stall_a = 1'b0, stall_b = 1'b0, rand_stall = 1'b0;
   logic lat_a = 1'b0, lat_b = 1'b0;
   int  ready_mode = 0;
   int  pop_a = 0, pop_b = 0, drain_a = 0, drain_b = 0;

   // reference model
   typedef struct packed {
      logic [1:0] g;
      logic       last;
      logic [7:0] d;
   } exp_t;
   exp_t       expq[$];
   logic [7:0] fbytes[$];
   int pa_base[$], pa_len[$], pb_base[$], pb_len[$];
   int model_last_b = 1;
   int exp_af = 0, exp_bf = 0, exp_trunc = 0;

   // monitor bookkeeping
   int   hs_cnt = 0, trunc_seen = 0, last_cyc = 0, fall_cyc = 0;
   logic prev_busy = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic refresh();
      a_empty       = stall_a || (aq.size() == 0);
      a_data        = (aq.size() != 0) ? aq[0][7:0] : 8'h00;
      a_last        = (aq.size() != 0) ? aq[0][8] : 1'b0;
      a_frame_avail = (a_cnt_frames > 0);
      b_empty       = stall_b || (bq.size() == 0);
      b_data        = (bq.size() != 0) ? bq[0][7:0] : 8'h00;
      b_last        = (bq.size() != 0) ? bq[0][8] : 1'b0;
      b_frame_avail = (b_cnt_frames > 0);
   endtask

   task automatic push_frame(input int port, input int len);
      int base;
      logic [7:0] v;
      base = fbytes.size();
      for (int i = 0; i < len; i++) begin
         v = 8'($urandom);
         fbytes.push_back(v);
         if (port == 0) aq.push_back({(i == len - 1), v});
         else           bq.push_back({(i == len - 1), v});
      end
      if (port == 0) begin
         a_cnt_frames++; pa_base.push_back(base); pa_len.push_back(len);
      end else begin
         b_cnt_frames++; pb_base.push_back(base); pb_len.push_back(len);
      end
   endtask

   // Frame-level round-robin: alternate on ties, otherwise serve whoever waits
   task automatic schedule();
      int port, base, len, sent;
      exp_t e;
      while (pa_len.size() != 0 || pb_len.size() != 0) begin
         if (pa_len.size() != 0 && pb_len.size() != 0) port = (model_last_b != 0) ? 0 : 1;
         else port = (pa_len.size() != 0) ? 0 : 1;
         if (port == 0) begin base = pa_base.pop_front(); len = pa_len.pop_front(); exp_af++; end
         else           begin base = pb_base.pop_front(); len = pb_len.pop_front(); exp_bf++; end
         model_last_b = port;
         sent = (len > MAX_LEN) ? MAX_LEN : len;
         if (len > MAX_LEN) exp_trunc++;
         for (int i = 0; i < sent; i++) begin
            e.g    = (port == 0) ? 2'b01 : 2'b10;
            e.last = (i == sent - 1);
            e.d    = fbytes[base + i];
            expq.push_back(e);
         end
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int  n;
      bit  done;
      n = 0; done = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         if (!busy && expq.size() == 0 && aq.size() == 0 && bq.size() == 0) done = 1;
      end
      #1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s: not idle after %0d cycles (expq=%0d), required idle", name, budget, expq.size());
      end
   endtask

   task automatic wait_hs(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (hs_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      checks++;
      if (hs_cnt < target) begin
         errors++;
         $display("FAIL %s: saw %0d handshakes, required %0d", name, hs_cnt, target);
      end
   endtask

   // FIFO pops, stall/ready generation, input refresh just after each edge
   always @(posedge clk) begin
      logic [8:0] w;
      cyc++;
      #1;
      if (lat_a && aq.size() != 0) begin w = aq.pop_front(); if (w[8]) a_cnt_frames--; pop_a++; end
      if (lat_b && bq.size() != 0) begin w = bq.pop_front(); if (w[8]) b_cnt_frames--; pop_b++; end
      lat_a = 1'b0;
      lat_b = 1'b0;
      if (rand_stall) begin
         stall_a = ($urandom_range(0, 7) == 0);
         stall_b = ($urandom_range(0, 7) == 0);
      end
      case (ready_mode)
         0:       tx_mac_ready = 1'b1;
         1:       tx_mac_ready = ~tx_mac_ready;
         default: tx_mac_ready = ($urandom_range(0, 3) != 0);
      endcase
      refresh();
   end

   // Monitor: protocol checks and scoreboard pops on each accepted byte
   always @(negedge clk) begin
      logic viol;
      logic rd;
      exp_t e;
      lat_a = a_rd_en;
      lat_b = b_rd_en;
      if (!reset) begin
         viol = 1'b0;
         if (a_rd_en && !grant[0]) viol = 1'b1;
         if (b_rd_en && !grant[1]) viol = 1'b1;
         if (a_rd_en && a_empty)   viol = 1'b1;
         if (b_rd_en && b_empty)   viol = 1'b1;
         if (grant == 2'b11)       viol = 1'b1;
         if (tx_mac_valid) begin
            rd = grant[1] ? b_rd_en : a_rd_en;
            if (rd != tx_mac_ready) viol = 1'b1;
         end
         checks++;
         if (viol) begin
            errors++;
            $display("FAIL protocol at cyc %0d: grant=%b a_rd=%b b_rd=%b valid=%b ready=%b a_empty=%b b_empty=%b",
                     cyc, grant, a_rd_en, b_rd_en, tx_mac_valid, tx_mac_ready, a_empty, b_empty);
         end
         if (!tx_mac_valid && a_rd_en) drain_a++;
         if (!tx_mac_valid && b_rd_en) drain_b++;
         if (tx_mac_valid && tx_mac_ready) begin
            hs_cnt++;
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL tx_byte: got unexpected byte %h last=%b grant=%b, expected none", tx_mac_data, tx_mac_last, grant);
            end else begin
               e = expq.pop_front();
               if ({tx_mac_data, tx_mac_last, grant} != {e.d, e.last, e.g}) begin
                  errors++;
                  $display("FAIL tx_byte: got data=%h last=%b grant=%b, expected data=%h last=%b grant=%b",
                           tx_mac_data, tx_mac_last, grant, e.d, e.last, e.g);
               end
            end
            if (tx_mac_last) last_cyc = cyc;
         end
         if (trunc_pulse) trunc_seen++;
         if (prev_busy && !busy) fall_cyc = cyc;
         prev_busy = busy;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0, tr0, dr0, pb0, n;
      reset = 1'b1;
      cfg_en = 1'b1;
      tx_mac_ready = 1'b1;
      refresh();
      repeat (3) @(negedge clk);
      check("reset_grant", grant, 0);
      check("reset_valid", tx_mac_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_trunc", trunc_pulse, 0);
      check("reset_a_frames", a_frames, 0);
      check("reset_b_frames", b_frames, 0);
      @(posedge clk); #2;
      reset = 1'b0;

      // single 64-byte frame from A, then the idle gap
      push_frame(0, 64);
      schedule();
      wait_idle("t1_idle", 2000);
      check("t1_a_frames", a_frames, exp_af);
      check("t1_busy_fall", fall_cyc - last_cyc, IFG_CYCLES + 1);

      // reset in the middle of a frame
      push_frame(0, 100);
      schedule();
      hs0 = hs_cnt;
      wait_hs("t5_reach_byte", hs0 + 29, 500);
      @(posedge clk); #2;
      reset = 1'b1;
      @(negedge clk);
      check("t5_grant", grant, 0);
      check("t5_valid", tx_mac_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_a_frames", a_frames, 0);
      check("t5_b_frames", b_frames, 0);
      aq.delete(); bq.delete(); a_cnt_frames = 0; b_cnt_frames = 0;
      expq.delete(); pa_base.delete(); pa_len.delete(); pb_base.delete(); pb_len.delete();
      model_last_b = 1; exp_af = 0; exp_bf = 0; exp_trunc = 0; trunc_seen = 0;
      refresh();
      @(posedge clk); #2;
      reset = 1'b0;

      // both ports, two frames each
      push_frame(0, $urandom_range(5, 40));
      push_frame(1, $urandom_range(5, 40));
      push_frame(0, $urandom_range(5, 40));
      push_frame(1, $urandom_range(5, 40));
      schedule();
      wait_idle("t2_idle", 2000);
      check("t2_a_frames", a_frames, 2);
      check("t2_b_frames", b_frames, 2);

      // over-length frame on B
      tr0 = trunc_seen; dr0 = drain_b; pb0 = pop_b;
      push_frame(1, 1600);
      schedule();
      wait_idle("t3_idle", 5000);
      check("t3_trunc_pulses", trunc_seen - tr0, 1);
      check("t3_drained", drain_b - dr0, 1600 - MAX_LEN);
      check("t3_b_pops", pop_b - pb0, 1600);
      check("t3_b_frames", b_frames, exp_bf);

      // ready toggling plus a mid-frame underrun on A
      ready_mode = 1;
      push_frame(0, 60);
      schedule();
      hs0 = hs_cnt;
      wait_hs("t4_mid", hs0 + 20, 500);
      @(posedge clk); #2;
      stall_a = 1'b1; refresh();
      repeat (5) @(posedge clk);
      #2;
      stall_a = 1'b0; refresh();
      wait_idle("t4_idle", 2000);
      ready_mode = 0;
      check("t4_a_frames", a_frames, exp_af);

      // cfg_en dropped during a transfer while B waits
      push_frame(0, 40);
      schedule();
      n = 0;
      while (grant != 2'b01 && n < 100) begin @(negedge clk); n++; end
      check("t6_a_granted", grant, 2'b01);
      @(posedge clk); #2;
      cfg_en = 1'b0;
      push_frame(1, 30);
      refresh();
      schedule();
      n = 0;
      while (busy && n < 500) begin @(negedge clk); n++; end
      check("t6_a_done", busy, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t6_hold_grant", grant, 0);
      end
      @(posedge clk); #2;
      cfg_en = 1'b1;
      @(negedge clk);
      check("t6_grant_before_sample", grant, 0);
      @(negedge clk);
      check("t6_grant_b", grant, 2'b10);
      wait_idle("t6_idle", 1000);
      check("t6_a_frames", a_frames, exp_af);
      check("t6_b_frames", b_frames, exp_bf);

      // randomized rounds with random backpressure and FIFO underruns
      ready_mode = 2;
      rand_stall = 1'b1;
      for (int r = 0; r < 4; r++) begin
         int na, nb;
         na = $urandom_range(0, 3);
         nb = $urandom_range(1, 3);
         for (int i = 0; i < na; i++) push_frame(0, $urandom_range(1, 80));
         for (int i = 0; i < nb; i++) push_frame(1, $urandom_range(1, 80));
         schedule();
         wait_idle("rand_idle", 20000);
      end
      rand_stall = 1'b0;
      stall_a = 1'b0;
      stall_b = 1'b0;
      ready_mode = 0;
      check("rand_a_frames", a_frames, exp_af);
      check("rand_b_frames", b_frames, exp_bf);
      check("total_trunc", trunc_seen, exp_trunc);
      check("scoreboard_empty", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
